// File: rtl/ultra_seg_display.sv
// ultra_seg_display
//
// Drives a common-anode 4-digit seven-segment display from the BCD range
// digits produced by the ultrasonic/UART stage. It also derives the parking
// proximity flags from the same range value.
//
// The four digits are scanned one slot at a time. Each slot lasts
// REFRESH_DIV clocks. At the end of every full frame (four slots) the input
// digits are snapshotted into shadow registers, so a digit that changes while
// a frame is being shown never produces a half-old, half-new display. The
// near/warn flags are recomputed from that same snapshot. While near is
// asserted the whole display blinks with a half-period of BLINK_FRAMES
// frames.
//
// Ports:
//   clk            system clock (single clock domain)
//   reset          synchronous, active-high reset
//   digit0..digit3 range digits in BCD (digit0 = units, digit3 = thousands)
//   an[3:0]        anode enables, active-low; an[i] selects digit i
//   seg[6:0]       segments {g,f,e,d,c,b,a}, active-low
//   near           snapshotted range < NEAR_THRESH
//   warn           NEAR_THRESH <= snapshotted range < WARN_THRESH
module ultra_seg_display #(
    parameter int REFRESH_DIV  = 12500,
    parameter int BLINK_FRAMES = 250,
    parameter int NEAR_THRESH  = 12,
    parameter int WARN_THRESH  = 36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       near,
    output logic       warn
);

    localparam logic [15:0] DIV_LAST   = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
    localparam logic [13:0] NEAR_LIMIT = 14'(NEAR_THRESH);
    localparam logic [13:0] WARN_LIMIT = 14'(WARN_THRESH);

    // Active-low segment patterns {g,f,e,d,c,b,a}. Non-BCD values show a dash.
    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h3F;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] div_cnt_reg,   div_cnt_next;
    logic [1:0]  scan_idx_reg,  scan_idx_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic [3:0]  shadow_reg [4];
    logic [3:0]  shadow_next [4];
    logic        near_reg,      near_next;
    logic        warn_reg,      warn_next;
    logic        blink_on_reg,  blink_on_next;
    logic [3:0]  an_reg,        an_next;
    logic [6:0]  seg_reg,       seg_next;

    logic        tick;
    logic        frame_end;

    // Live inputs gathered into an array so the per-digit logic can be
    // generated uniformly.
    logic [3:0]  digit_in [4];
    assign digit_in[0] = digit0;
    assign digit_in[1] = digit1;
    assign digit_in[2] = digit2;
    assign digit_in[3] = digit3;

    assign tick      = (div_cnt_reg == DIV_LAST);
    assign frame_end = tick && (scan_idx_reg == 2'd3);

    // ------------------------------------------------------------------
    // Range evaluation of the incoming snapshot
    // ------------------------------------------------------------------
    // The flags are computed from the live digits because they are latched
    // on the same edge that loads the shadow registers. The result is
    // therefore exactly the flag for the new snapshot.
    logic [3:0]  digit_ok;
    logic        snap_valid;
    logic [13:0] range_val;
    logic        near_hit;
    logic        warn_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_valid
            assign digit_ok[gi] = (digit_in[gi] <= 4'd9);
        end
    endgenerate

    assign snap_valid = &digit_ok;
    // A non-BCD digit can overflow 14 bits here. That result is discarded
    // because snap_valid is low in that case.
    assign range_val  = 14'(digit_in[3]) * 14'd1000
                      + 14'(digit_in[2]) * 14'd100
                      + 14'(digit_in[1]) * 14'd10
                      + 14'(digit_in[0]);
    assign near_hit   = snap_valid && (range_val < NEAR_LIMIT);
    assign warn_hit   = snap_valid && !near_hit && (range_val < WARN_LIMIT);

    // ------------------------------------------------------------------
    // Per-digit display decode from the shadow registers
    // ------------------------------------------------------------------
    logic [3:0] zero_flag;
    logic [3:0] blank_flag;
    logic [6:0] digit_seg [4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign zero_flag[gi] = (shadow_reg[gi] == 4'd0);
            assign digit_seg[gi] = seg_encode(shadow_reg[gi]);
            // A digit is a leading zero only if it and every digit above it
            // are zero. A dash (value > 9) is non-zero, so it both shows and
            // stops blanking further down. The units digit always shows.
            if (gi == 0) begin : g_units
                assign blank_flag[gi] = 1'b0;
            end else begin : g_upper
                assign blank_flag[gi] = &zero_flag[3:gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan / snapshot / blink control
    // ------------------------------------------------------------------
    always_comb begin
        div_cnt_next   = tick ? 16'd0 : div_cnt_reg + 16'd1;
        scan_idx_next  = tick ? scan_idx_reg + 2'd1 : scan_idx_reg;
        frame_cnt_next = frame_cnt_reg;
        shadow_next    = shadow_reg;
        near_next      = near_reg;
        warn_next      = warn_reg;
        blink_on_next  = blink_on_reg;

        if (frame_end) begin
            for (int i = 0; i < 4; i++) begin
                shadow_next[i] = digit_in[i];
            end
            near_next = near_hit;
            warn_next = warn_hit;

            // The blink follows the new near value. The frame that first
            // becomes near is shown lit and already counts toward the first
            // half-period.
            if (!near_hit) begin
                frame_cnt_next = 16'd0;
                blink_on_next  = 1'b1;
            end else if (frame_cnt_reg == BLINK_LAST) begin
                frame_cnt_next = 16'd0;
                blink_on_next  = !blink_on_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered display drive
    // ------------------------------------------------------------------
    always_comb begin
        an_next  = 4'b1111;
        seg_next = 7'h7F;
        if (blink_on_reg && !blank_flag[scan_idx_reg]) begin
            an_next[scan_idx_reg] = 1'b0;
            seg_next              = digit_seg[scan_idx_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg   <= 16'd0;
            scan_idx_reg  <= 2'd0;
            frame_cnt_reg <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                shadow_reg[i] <= 4'd0;
            end
            near_reg      <= 1'b0;
            warn_reg      <= 1'b0;
            blink_on_reg  <= 1'b1;
            an_reg        <= 4'b1111;
            seg_reg       <= 7'h7F;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            scan_idx_reg  <= scan_idx_next;
            frame_cnt_reg <= frame_cnt_next;
            shadow_reg    <= shadow_next;
            near_reg      <= near_next;
            warn_reg      <= warn_next;
            blink_on_reg  <= blink_on_next;
            an_reg        <= an_next;
            seg_reg       <= seg_next;
        end
    end

    assign an   = an_reg;
    assign seg  = seg_reg;
    assign near = near_reg;
    assign warn = warn_reg;

endmodule

// File: tb/tb_ultra_seg_display.sv
// tb_ultra_seg_display
//
// Self-checking bench for ultra_seg_display with REFRESH_DIV=4 and
// BLINK_FRAMES=2. The reference model tracks the elapsed clocks since reset
// release. From that count it derives the slot, the frame boundaries, the
// snapshot and the blink phase arithmetically. The expected an/seg/near/warn
// are then derived from those values.
module tb_ultra_seg_display;

    localparam int RD    = 4;
    localparam int BF    = 2;
    localparam int NT    = 12;
    localparam int WT    = 36;
    localparam int FRAME = 4 * RD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din [4];
    logic [3:0] an;
    logic [6:0] seg;
    logic       near;
    logic       warn;

    always #5 clk = ~clk;

    ultra_seg_display #(
        .REFRESH_DIV (RD),
        .BLINK_FRAMES(BF),
        .NEAR_THRESH (NT),
        .WARN_THRESH (WT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .digit0(din[0]),
        .digit1(din[1]),
        .digit2(din[2]),
        .digit3(din[3]),
        .an    (an),
        .seg   (seg),
        .near  (near),
        .warn  (warn)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_t;        // clock edges since reset release
    int         m_snap [4]; // snapshotted digits
    int         m_nf;       // consecutive frames with near asserted
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_near;
    logic       exp_warn;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // One clock: apply the model for the edge, then move to the falling edge
    // so the caller samples the outputs away from the active edge.
    task automatic step();
        int  slot;
        bit  blank;
        bit  lit;
        bit  valid;
        int  range_v;
        @(posedge clk);
        if (reset) begin
            m_t      = 0;
            m_nf     = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 0;
            exp_an   = 4'hF;
            exp_seg  = 7'h7F;
            exp_near = 1'b0;
            exp_warn = 1'b0;
        end else begin
            // Outputs show the state that held before this edge.
            slot  = (m_t / RD) % 4;
            blank = (slot != 0);
            for (int j = slot; j < 4; j++) if (m_snap[j] != 0) blank = 0;
            lit   = ((m_nf / BF) % 2) == 0;
            if (!lit || blank) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = 4'hF & ~(4'h1 << slot);
                exp_seg = seg_of(m_snap[slot]);
            end
            m_t++;
            if (m_t % FRAME == 0) begin
                valid = 1;
                for (int i = 0; i < 4; i++) begin
                    m_snap[i] = int'(din[i]);
                    if (m_snap[i] > 9) valid = 0;
                end
                range_v  = m_snap[3] * 1000 + m_snap[2] * 100 + m_snap[1] * 10 + m_snap[0];
                exp_near = valid && (range_v < NT);
                exp_warn = valid && (range_v >= NT) && (range_v < WT);
                m_nf     = exp_near ? m_nf + 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_range(input int v);
        din[0] = 4'(v % 10);
        din[1] = 4'((v / 10) % 10);
        din[2] = 4'((v / 100) % 10);
        din[3] = 4'((v / 1000) % 10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 4'd9;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({an, seg, near, warn} !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold c=%0d an=%b seg=%h near=%b warn=%b required an=1111 seg=7f near=0 warn=0",
                         c, an, seg, near, warn);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            checks++;
            if ({an, seg, near, warn} !== {exp_an, exp_seg, exp_near, exp_warn}) begin
                errors++;
                $display("FAIL reset_release t=%0d an=%b/%b seg=%h/%h near=%b/%b warn=%b/%b (got/required)",
                         m_t, an, exp_an, seg, exp_seg, near, exp_near, warn, exp_warn);
            end
            if (c >= FRAME) begin
                checks++;
                if (seg !== 7'h10) begin
                    errors++;
                    $display("FAIL reset_first_frame t=%0d seg=%h required 10", m_t, seg);
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_patterns();
        int tbl [6] = '{48, 25, 11, 12, 35, 36};
        for (int p = 0; p < 6; p++) begin
            set_range(tbl[p]);
            for (int c = 0; c < 2 * FRAME + 3; c++) begin
                step();
                checks++;
                if ({an, seg, near, warn} !== {exp_an, exp_seg, exp_near, exp_warn}) begin
                    errors++;
                    $display("FAIL pattern_%0d t=%0d an=%b/%b seg=%h/%h near=%b/%b warn=%b/%b (got/required)",
                             tbl[p], m_t, an, exp_an, seg, exp_seg, near, exp_near, warn, exp_warn);
                end
            end
            checks++;
            if ({near, warn} !== {tbl[p] < NT, tbl[p] >= NT && tbl[p] < WT}) begin
                errors++;
                $display("FAIL flags_%0d near=%b warn=%b required near=%b warn=%b",
                         tbl[p], near, warn, tbl[p] < NT, tbl[p] >= NT && tbl[p] < WT);
            end
            $display("pattern range=%0d near=%b warn=%b", tbl[p], near, warn);
        end
    endtask

    task automatic test_near_blink();
        int dark_cycles = 0;
        set_range(9);
        for (int c = 0; c < 10 * FRAME; c++) begin
            step();
            if (an === 4'hF) dark_cycles++;
            checks++;
            if ({an, seg, near, warn} !== {exp_an, exp_seg, exp_near, exp_warn}) begin
                errors++;
                $display("FAIL near_blink t=%0d an=%b/%b seg=%h/%h near=%b/%b warn=%b/%b (got/required)",
                         m_t, an, exp_an, seg, exp_seg, near, exp_near, warn, exp_warn);
            end
        end
        // Only slot0 is ever lit for range 9, so a steady display would be
        // dark three slots in four. Blinking must darken more than that.
        checks++;
        if (dark_cycles <= (10 * FRAME * 3) / 4 + RD) begin
            errors++;
            $display("FAIL blink_dark_cycles got=%0d required more than %0d", dark_cycles, (10 * FRAME * 3) / 4 + RD);
        end
        $display("near_blink dark_cycles=%0d", dark_cycles);
    endtask

    task automatic test_invalid_tear();
        din[3] = 4'd0; din[2] = 4'd0; din[1] = 4'hA; din[0] = 4'd0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            // Change the units digit mid-frame once the dash pattern is up.
            if (c >= 2 * FRAME && (m_t % FRAME) == FRAME / 2) din[0] = 4'd5;
            step();
            checks++;
            if ({an, seg, near, warn} !== {exp_an, exp_seg, exp_near, exp_warn}) begin
                errors++;
                $display("FAIL invalid_tear t=%0d an=%b/%b seg=%h/%h near=%b/%b warn=%b/%b (got/required)",
                         m_t, an, exp_an, seg, exp_seg, near, exp_near, warn, exp_warn);
            end
        end
        $display("invalid_tear digit0 now %0d", din[0]);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int len;
            if ($urandom_range(0, 1) == 0) set_range(int'($urandom_range(0, 60)));
            else set_range(int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 5) == 0) din[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
            len = int'($urandom_range(1, 2 * FRAME + 4));
            for (int c = 0; c < len; c++) begin
                step();
                checks++;
                if ({an, seg, near, warn} !== {exp_an, exp_seg, exp_near, exp_warn}) begin
                    errors++;
                    $display("FAIL random_%0d t=%0d an=%b/%b seg=%h/%h near=%b/%b warn=%b/%b (got/required)",
                             n, m_t, an, exp_an, seg, exp_seg, near, exp_near, warn, exp_warn);
                end
            end
            $display("random %0d digits=%h%h%h%h cycles=%0d", n, din[3], din[2], din[1], din[0], len);
        end
    endtask

    task automatic test_reset_mid_scan();
        set_range(7);
        for (int c = 0; c < 5 * FRAME + 1 + int'($urandom_range(0, FRAME - 2)); c++) begin
            step();
            checks++;
            if ({an, seg, near, warn} !== {exp_an, exp_seg, exp_near, exp_warn}) begin
                errors++;
                $display("FAIL pre_reset t=%0d an=%b/%b seg=%h/%h near=%b/%b (got/required)",
                         m_t, an, exp_an, seg, exp_seg, near, exp_near);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({an, seg, near, warn} !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset an=%b seg=%h near=%b warn=%b required an=1111 seg=7f near=0 warn=0",
                     an, seg, near, warn);
        end
        for (int c = 0; c < 3 * FRAME; c++) begin
            step();
            checks++;
            if ({an, seg, near, warn} !== {exp_an, exp_seg, exp_near, exp_warn}) begin
                errors++;
                $display("FAIL post_reset t=%0d an=%b/%b seg=%h/%h near=%b/%b warn=%b/%b (got/required)",
                         m_t, an, exp_an, seg, exp_seg, near, exp_near, warn, exp_warn);
            end
        end
        checks++;
        if (near !== 1'b1) begin
            errors++;
            $display("FAIL near_reassert near=%b required 1", near);
        end
        $display("reset_mid_scan done");
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 4'd0;
        m_t = 0;
        m_nf = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 0;
        test_reset();
        test_patterns();
        test_near_blink();
        test_invalid_tear();
        test_random();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
